qif_synapse: RTL and testbench
==============================

# qif_synapse

Spike-driven synaptic current generator; the input side of the QIF neuron. Accepts single-cycle presynaptic spike pulses on N_IN lines and adds a programmable signed weight per spike into an 8-bit signed current accumulator. The accumulator decays exponentially toward zero, and the result drives the neuron's 8-bit signed `I_syn` input. Multiple spikes in one cycle are queued in a pending register and served one per cycle by fixed-priority arbitration.

## Interface
- N_IN, 4: number of presynaptic spike inputs (2..16).
- W_INIT, 8'sd16: reset value of every weight register.
- DECAY_SHIFT, 3: decay step is `acc >>> DECAY_SHIFT`.
- DECAY_PERIOD, 4: cycles between decay ticks (≥1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- spike_in  in  N_IN  one pulse per spike per bit; a level held high counts as one spike per cycle.
- w_we  in  1  weight write enable.
- w_addr  in  clog2(N_IN)  weight index to write.
- w_data  in  8 signed  weight value.
- I_syn  out  8 signed  synaptic current (registered accumulator).
- busy  out  1  `|pending`.
- drop_cnt  out  8  saturating count of coalesced (lost) spikes.

## Operation
- State:
  - `pending[N_IN]`
  - `acc` (8b signed, drives `I_syn`)
  - `weight[N_IN]` (8b signed)
  - `dec_cnt` (0..DECAY_PERIOD-1)
  - `drop_cnt`
- Reset values: `acc`=0 (so `I_syn`=0), `pending`=0, `busy`=0, `drop_cnt`=0, `dec_cnt`=0, all weights = W_INIT. Reset asserted mid-operation discards all pending spikes immediately.
- Capture: each edge, `pending_next = (pending & ~grant) | spike_in`.
- Arbitration: `grant` selects the lowest-index set bit of `pending`. At most one grant per cycle.
- Coalescing: a `spike_in` bit that is already set in `pending` and is not granted this cycle is a drop. `drop_cnt` adds the number of such bits per cycle and saturates at 255. A spike on the granted bit in the same cycle is not a drop; the bit stays pending.
- Decay tick: asserted when `dec_cnt == DECAY_PERIOD-1`. `dec_cnt` wraps to 0 on the tick and otherwise increments.
- Accumulator update:
  - Compute in 10-bit signed: `s = acc - (tick ? acc >>> DECAY_SHIFT : 0) + (grant ? weight[grant_idx] : 0)`.
  - Saturate `s` to [-128, 127]. If a tick and a grant coincide, decay applies first, then the add.
- Decay asymmetry (inherent to the arithmetic shift):
  - Positive values stall at a floor of 2^DECAY_SHIFT − 1 (7 for shift 3).
  - Negative values reach 0.
- Weight write: `weight[w_addr] <= w_data` on the edge where `w_we`=1. If the same index is granted in that cycle, the grant uses the old weight. `w_addr` ≥ N_IN is ignored.

## Timing
- Spike on `spike_in` in cycle t:
  - pending at edge t;
  - granted in cycle t+1 if it is the highest priority;
  - `I_syn` updated after edge t+1, visible in cycle t+2.
- Minimum latency from spike to `I_syn` is 2 cycles. With k higher-priority bits pending, latency is 2+k.
- Throughput: one spike per cycle. Sustained simultaneous activity above that rate is lost and counted in `drop_cnt`.
- First decay tick occurs on the DECAY_PERIOD-th edge after reset release.
- `busy` is registered and reflects `pending` after each edge.
- No combinational path from any input to any output.

## Test plan
- Reset: assert `rst_n`=1 mid-run with `pending` nonzero → within the same cycle `I_syn`=0, `busy`=0, `drop_cnt`=0. After release, no queued spike is ever applied.
- Single spike plus decay (defaults): pulse `spike_in[0]` at cycle 0 → `I_syn`=16 at cycle 2. Subsequent ticks give 14, 13, 12, 11, 10, 9, 8, 7, then hold at 7. With `weight[0]`=-16: -14, -12, -10, -8, -7, -6, …, -1, 0.
- Priority queue (DECAY_PERIOD=64): `spike_in`=4'b1111 for one cycle → grants 0, 1, 2, 3 on consecutive cycles. `I_syn` reads 16, 32, 48, 64 on cycles 2..5. `busy` is high for exactly 4 cycles.
- Saturation: write `weight[1]`=127, then pulse `spike_in[1]` 3 times → `I_syn` clamps at 127. Write `weight[1]`=-128, pulse twice → `I_syn` = -128 with no wrap.
- Coalescing: `spike_in`=4'b1111 held for 2 cycles → `drop_cnt`=3 (bit 0 was granted and is not a drop). Then 5 spikes are applied in total and `I_syn` reaches 80 (DECAY_PERIOD=64).
- Write/grant collision: `weight[0]`=16, then in one cycle `w_we`=1 with `w_addr`=0, `w_data`=50 while bit 0 is granted → `I_syn` increases by 16. The next spike on bit 0 increases it by 50.

Source files
------------

// File: rtl/qif_synapse_if.sv
// Spike, weight-programming and current-output bundle between a spike source and qif_synapse.
interface qif_synapse_if #(
    parameter int N_IN = 4
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]   spike_in;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic signed [7:0] w_data;
    logic signed [7:0] I_syn;
    logic              busy;
    logic [7:0]        drop_cnt;

    modport master (
        output spike_in, w_we, w_addr, w_data,
        input  I_syn, busy, drop_cnt
    );

    modport slave (
        input  spike_in, w_we, w_addr, w_data,
        output I_syn, busy, drop_cnt
    );
endinterface

// File: rtl/qif_synapse.sv
// Spike-driven synaptic current: queued spikes add per-line weights into a saturating
// 8-bit accumulator that decays toward zero every DECAY_PERIOD cycles.
module qif_synapse #(
    parameter int                N_IN         = 4,
    parameter logic signed [7:0] W_INIT       = 8'sd16,
    parameter int                DECAY_SHIFT  = 3,
    parameter int                DECAY_PERIOD = 4
) (
    input logic          clk,
    input logic          rst_n,
    qif_synapse_if.slave bus
);
    localparam int            AW       = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int            DW       = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_PERIOD - 1);

    logic [N_IN-1:0]   pending;
    logic [N_IN-1:0]   grant;
    logic [N_IN-1:0]   drops;
    logic              grant_any;
    logic [AW-1:0]     grant_idx;
    logic signed [7:0] acc;
    logic signed [7:0] acc_next;
    logic signed [7:0] weight [N_IN];
    logic [DW-1:0]     dec_cnt;
    logic              tick;
    logic [7:0]        drop_cnt;
    logic [7:0]        drop_next;
    logic [8:0]        drop_sum;
    logic signed [9:0] sum;
    logic              addr_ok;

    // Lowest index wins: scan from the top so the last hit is the smallest set bit.
    always_comb begin
        // NOTE: every combinational output is given a default first so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = AW'(i);
                grant_any = 1'b1;
            end
        end
    end

    // A spike landing on a bit that stays pending merges into it and is lost.
    assign drops = bus.spike_in & pending & ~grant;

    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < N_IN; i++) begin
            drop_sum = drop_sum + 9'(drops[i]);
        end
        drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign tick = (dec_cnt == DEC_LAST);

    // Decay is taken from the pre-add value, so a coincident grant adds after the decay.
    always_comb begin
        sum = $signed({{2{acc[7]}}, acc});
        if (tick) begin
            sum = sum - (sum >>> DECAY_SHIFT);
        end
        if (grant_any) begin
            sum = sum + $signed({{2{weight[grant_idx][7]}}, weight[grant_idx]});
        end
        if (sum > 10'sd127) begin
            acc_next = 8'sd127;
        end else if (sum < -10'sd128) begin
            acc_next = -8'sd128;
        end else begin
            acc_next = sum[7:0];
        end
    end

    if ((1 << AW) > N_IN) begin : g_addr_chk
        assign addr_ok = (bus.w_addr < AW'(N_IN));
    end else begin : g_addr_all
        assign addr_ok = 1'b1;
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pending  <= '0;
            acc      <= '0;
            dec_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= (pending & ~grant) | bus.spike_in;
            acc      <= acc_next;
            dec_cnt  <= tick ? '0 : dec_cnt + DW'(1);
            drop_cnt <= drop_next;
        end
    end

    // NOTE: the weight file must come up at W_INIT, so it is reset like any other register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                weight[i] <= W_INIT;
            end
        end else if (bus.w_we && addr_ok) begin
            weight[bus.w_addr] <= bus.w_data;
        end
    end

    assign bus.I_syn    = acc;
    assign bus.busy     = |pending;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_qif_synapse.sv
// Self-checking bench: two synapses (fast and slow decay) share one random/directed stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_qif_synapse;
    localparam int PER_A = 4;
    localparam int PER_B = 64;
    localparam int SHIFT = 3;

    logic              clk;
    logic              rst_n;
    logic [3:0]        spike;
    logic              w_we;
    logic [1:0]        w_addr;
    logic signed [7:0] w_data;

    int checks = 0;
    int errors = 0;

    qif_synapse_if #(.N_IN(4)) bus_a ();
    qif_synapse_if #(.N_IN(4)) bus_b ();

    assign bus_a.spike_in = spike;
    assign bus_a.w_we     = w_we;
    assign bus_a.w_addr   = w_addr;
    assign bus_a.w_data   = w_data;
    assign bus_b.spike_in = spike;
    assign bus_b.w_we     = w_we;
    assign bus_b.w_addr   = w_addr;
    assign bus_b.w_data   = w_data;

    qif_synapse #(.N_IN(4), .W_INIT(8'sd16), .DECAY_SHIFT(SHIFT), .DECAY_PERIOD(PER_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    qif_synapse #(.N_IN(4), .W_INIT(8'sd16), .DECAY_SHIFT(SHIFT), .DECAY_PERIOD(PER_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int         m_acc  [2];
    logic [3:0] m_pend [2];
    int         m_w    [2][4];
    int         m_dcnt [2];
    int         m_drop [2];

    function automatic int period_of(input int k);
        return (k == 0) ? PER_A : PER_B;
    endfunction

    task automatic model_reset(input int k);
        m_acc[k]  = 0;
        m_pend[k] = 4'b0000;
        m_dcnt[k] = 0;
        m_drop[k] = 0;
        for (int i = 0; i < 4; i++) m_w[k][i] = 16;
    endtask

    task automatic model_step(input int k);
        int g;
        int nd;
        int v;
        bit tk;
        g  = -1;
        nd = 0;
        for (int i = 0; i < 4; i++) if (m_pend[k][i] && g < 0) g = i;
        for (int i = 0; i < 4; i++) if (spike[i] && m_pend[k][i] && i != g) nd++;
        m_drop[k] = (m_drop[k] + nd > 255) ? 255 : m_drop[k] + nd;
        tk = (m_dcnt[k] == period_of(k) - 1);
        v  = m_acc[k];
        if (tk) v = v - $rtoi($floor(real'(v) / real'(1 << SHIFT)));
        if (g >= 0) v = v + m_w[k][g];
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        m_acc[k] = v;
        if (g >= 0) m_pend[k][g] = 1'b0;
        m_pend[k] = m_pend[k] | spike;
        m_dcnt[k] = tk ? 0 : m_dcnt[k] + 1;
        if (w_we) m_w[k][w_addr] = w_data;
    endtask

    always @(posedge clk or posedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n) model_reset(k);
            else       model_step(k);
        end
    end

    always @(negedge clk) begin
        check("a.I_syn",    $signed(bus_a.I_syn), m_acc[0]);
        check("a.busy",     bus_a.busy, (m_pend[0] != 0) ? 1 : 0);
        check("a.drop_cnt", bus_a.drop_cnt, m_drop[0]);
        check("b.I_syn",    $signed(bus_b.I_syn), m_acc[1]);
        check("b.busy",     bus_b.busy, (m_pend[1] != 0) ? 1 : 0);
        check("b.drop_cnt", bus_b.drop_cnt, m_drop[1]);
    end

    // Applies inputs for the next rising edge and returns at the following falling edge.
    task automatic drive(input logic [3:0] sp, input logic we, input logic [1:0] a,
                         input logic signed [7:0] d);
        spike  = sp;
        w_we   = we;
        w_addr = a;
        w_data = d;
        @(negedge clk);
        spike  = 4'b0000;
        w_we   = 1'b0;
        w_addr = 2'd0;
        w_data = 8'sd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 1'b0, 2'd0, 8'sd0);
    endtask

    task automatic do_reset;
        #2 rst_n = 1'b1;
        #1;
        check("rst.a.I_syn", $signed(bus_a.I_syn), 0);
        check("rst.a.busy",  bus_a.busy, 0);
        check("rst.a.drop",  bus_a.drop_cnt, 0);
        check("rst.b.I_syn", $signed(bus_b.I_syn), 0);
        check("rst.b.busy",  bus_b.busy, 0);
        check("rst.b.drop",  bus_b.drop_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    int seq_q[$];

    // Records each distinct value dut_a's current takes over n idle cycles.
    task automatic collect(input int n);
        int last;
        seq_q.delete();
        last = $signed(bus_a.I_syn);
        for (int i = 0; i < n; i++) begin
            idle(1);
            if ($signed(bus_a.I_syn) != last) begin
                last = $signed(bus_a.I_syn);
                seq_q.push_back(last);
            end
        end
    endtask

    initial begin
        int exp_pos [9]  = '{16, 14, 13, 12, 11, 10, 9, 8, 7};
        int exp_neg [13] = '{-16, -14, -12, -10, -8, -7, -6, -5, -4, -3, -2, -1, 0};

        rst_n  = 1'b1;
        spike  = 4'b0000;
        w_we   = 1'b0;
        w_addr = 2'd0;
        w_data = 8'sd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        check("init.I_syn", $signed(bus_a.I_syn), 0);
        check("init.busy",  bus_a.busy, 0);

        // Positive decay: 16 then down to the floor of 7, where it holds.
        drive(4'b0001, 1'b0, 2'd0, 8'sd0);
        collect(60);
        check("pos.len", seq_q.size(), 9);
        for (int i = 0; i < 9 && i < seq_q.size(); i++) check("pos.seq", seq_q[i], exp_pos[i]);

        // Reset with spikes still queued: nothing queued survives.
        drive(4'b1111, 1'b0, 2'd0, 8'sd0);
        do_reset();
        idle(10);
        check("flush.a.I_syn", $signed(bus_a.I_syn), 0);
        check("flush.b.I_syn", $signed(bus_b.I_syn), 0);

        // Negative decay reaches zero.
        drive(4'b0000, 1'b1, 2'd0, -8'sd16);
        drive(4'b0001, 1'b0, 2'd0, 8'sd0);
        collect(70);
        check("neg.len", seq_q.size(), 13);
        for (int i = 0; i < 13 && i < seq_q.size(); i++) check("neg.seq", seq_q[i], exp_neg[i]);

        // Priority queue on the slow-decay instance.
        do_reset();
        drive(4'b1111, 1'b0, 2'd0, 8'sd0);
        check("prio.busy0", bus_b.busy, 1);
        check("prio.isyn0", $signed(bus_b.I_syn), 0);
        for (int j = 0; j < 4; j++) begin
            idle(1);
            check("prio.isyn", $signed(bus_b.I_syn), 16 * (j + 1));
            check("prio.busy", bus_b.busy, (j < 3) ? 1 : 0);
        end

        // Coalescing: three drops, five applied spikes.
        do_reset();
        drive(4'b1111, 1'b0, 2'd0, 8'sd0);
        drive(4'b1111, 1'b0, 2'd0, 8'sd0);
        check("coal.drop", bus_b.drop_cnt, 3);
        idle(4);
        check("coal.isyn", $signed(bus_b.I_syn), 80);

        // Saturation at both rails.
        do_reset();
        drive(4'b0000, 1'b1, 2'd1, 8'sd127);
        for (int j = 0; j < 3; j++) begin
            drive(4'b0010, 1'b0, 2'd0, 8'sd0);
            idle(1);
        end
        check("sat.hi", $signed(bus_b.I_syn), 127);
        drive(4'b0000, 1'b1, 2'd1, -8'sd128);
        for (int j = 0; j < 2; j++) begin
            drive(4'b0010, 1'b0, 2'd0, 8'sd0);
            idle(1);
        end
        check("sat.lo", $signed(bus_b.I_syn), -128);

        // Weight write colliding with a grant on the same line uses the old weight.
        do_reset();
        drive(4'b0001, 1'b0, 2'd0, 8'sd0);
        drive(4'b0000, 1'b1, 2'd0, 8'sd50);
        check("coll.old", $signed(bus_b.I_syn), 16);
        drive(4'b0001, 1'b0, 2'd0, 8'sd0);
        idle(1);
        check("coll.new", $signed(bus_b.I_syn), 66);

        // Random traffic with occasional weight writes and resets.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] sp;
            sp = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) sp = 4'b0000;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive(sp, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
